// File: rtl/euler_engine.sv
// euler_engine: one explicit Euler step x_{n+1} = x_n + h*A*x_n over a shared
// 64-bit state RAM, using 16-bit signed fixed point held in the low word bits.
// Responder side of the Euler_Enable / Euler_End level handshake.
module euler_engine #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int FRAC_BITS     = 8,
  parameter int MAX_N         = 50,
  parameter int N_ADD         = 0,
  parameter int H_ADD         = 4,
  parameter int X_PROCESS_ADD = 6,
  parameter int X_INIT_ADD    = 56,
  parameter int A_BASE_ADD    = 156
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Euler_Enable,
  output logic                     Euler_End,
  output logic                     Euler_Memory_WR_Enable,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_A,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_B,
  input  logic [DATA_WIDTH-1:0]    RAM_Data_RD_A,
  input  logic [DATA_WIDTH-1:0]    RAM_Data_RD_B,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address_WR,
  output logic [DATA_WIDTH-1:0]    RAM_Data_WR,
  output logic                     Error_Flag
);

  localparam int AW = ADDRESS_WIDTH;

  localparam logic [AW-1:0] N_ADDR     = AW'(N_ADD);
  localparam logic [AW-1:0] H_ADDR     = AW'(H_ADD);
  localparam logic [AW-1:0] XPROC_ADDR = AW'(X_PROCESS_ADD);
  localparam logic [AW-1:0] XINIT_ADDR = AW'(X_INIT_ADD);
  localparam logic [AW-1:0] ABASE_ADDR = AW'(A_BASE_ADD);
  localparam logic [AW-1:0] MAX_N_VAL  = AW'(MAX_N);

  typedef enum logic [2:0] {
    IDLE, LOAD, LATCH, ROW_INIT, FETCH, MAC, UPDATE, DONE
  } state_t;

  state_t                state_reg;
  logic [AW-1:0]         n_reg;
  logic signed [15:0]    h_reg;
  logic signed [15:0]    acc_reg;
  logic signed [15:0]    xi_reg;
  logic [AW-1:0]         i_reg;
  logic [AW-1:0]         j_reg;
  logic [AW-1:0]         aptr_reg;

  // True when a 32-bit signed value survives truncation to 16 bits.
  function automatic logic fits16(input logic signed [31:0] v);
    return v[31:15] == {17{v[15]}};
  endfunction

  // Datapath: one MAC term, the running sum, and, looked ahead during the
  // last MAC of a row, the row's final update so the write can be registered
  // on the edge entering UPDATE.
  logic signed [15:0] a_word;
  logic signed [15:0] b_word;
  logic signed [31:0] prod_full;
  logic signed [31:0] p_wide;
  logic signed [15:0] p16;
  logic [16:0]        acc_sum;
  logic signed [15:0] acc_next;
  logic               mac_ovf;
  logic signed [15:0] xi_eff;
  logic signed [31:0] s_full;
  logic signed [31:0] s_wide;
  logic signed [15:0] s16;
  logic [16:0]        xn_sum;
  logic signed [15:0] xn_next;
  logic               upd_ovf;
  logic [AW-1:0]      j_inc;
  logic [AW-1:0]      i_inc;
  logic [AW-1:0]      n_in;

  // Combinational arithmetic feeding the FSM; every result is range-checked.
  always_comb begin
    a_word    = RAM_Data_RD_A[15:0];
    b_word    = RAM_Data_RD_B[15:0];
    prod_full = a_word * b_word;
    p_wide    = prod_full >>> FRAC_BITS;
    p16       = p_wide[15:0];
    acc_sum   = {acc_reg[15], acc_reg} + {p16[15], p16};
    acc_next  = acc_sum[15:0];
    mac_ovf   = !fits16(p_wide) || (acc_sum[16] != acc_sum[15]);
    xi_eff    = (j_reg == i_reg) ? b_word : xi_reg;
    s_full    = h_reg * acc_next;
    s_wide    = s_full >>> FRAC_BITS;
    s16       = s_wide[15:0];
    xn_sum    = {xi_eff[15], xi_eff} + {s16[15], s16};
    xn_next   = xn_sum[15:0];
    upd_ovf   = !fits16(s_wide) || (xn_sum[16] != xn_sum[15]);
    j_inc     = j_reg + 1'b1;
    i_inc     = i_reg + 1'b1;
    n_in      = RAM_Data_RD_A[AW-1:0];
  end

  // Control FSM with registered outputs; outputs are set on the edge that
  // enters the state they belong to, so read addresses are stable in LOAD
  // and FETCH and the RAM data appears in LATCH and MAC.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg              <= IDLE;
      n_reg                  <= '0;
      h_reg                  <= '0;
      acc_reg                <= '0;
      xi_reg                 <= '0;
      i_reg                  <= '0;
      j_reg                  <= '0;
      aptr_reg               <= '0;
      Euler_End              <= 1'b0;
      Euler_Memory_WR_Enable <= 1'b0;
      RAM_Address_RD_A       <= '0;
      RAM_Address_RD_B       <= '0;
      RAM_Address_WR         <= '0;
      RAM_Data_WR            <= '0;
      Error_Flag             <= 1'b0;
    end else begin
      Euler_Memory_WR_Enable <= 1'b0;
      case (state_reg)
        IDLE: begin
          Euler_End <= 1'b0;
          if (Euler_Enable) begin
            RAM_Address_RD_A <= N_ADDR;
            RAM_Address_RD_B <= H_ADDR;
            state_reg        <= LOAD;
          end
        end
        LOAD: begin
          state_reg <= LATCH;
        end
        LATCH: begin
          n_reg    <= n_in;
          h_reg    <= RAM_Data_RD_B[15:0];
          i_reg    <= '0;
          aptr_reg <= ABASE_ADDR;
          if (n_in == '0) begin
            Euler_End <= 1'b1;
            state_reg <= DONE;
          end else if (n_in > MAX_N_VAL) begin
            Error_Flag <= 1'b1;
            Euler_End  <= 1'b1;
            state_reg  <= DONE;
          end else begin
            state_reg <= ROW_INIT;
          end
        end
        ROW_INIT: begin
          // aptr_reg already points at A[i][0]: it runs on across rows.
          acc_reg          <= '0;
          j_reg            <= '0;
          RAM_Address_RD_A <= aptr_reg;
          RAM_Address_RD_B <= XINIT_ADDR;
          state_reg        <= FETCH;
        end
        FETCH: begin
          state_reg <= MAC;
        end
        MAC: begin
          if (mac_ovf) begin
            Error_Flag <= 1'b1;
            Euler_End  <= 1'b1;
            state_reg  <= DONE;
          end else begin
            acc_reg  <= acc_next;
            j_reg    <= j_inc;
            aptr_reg <= aptr_reg + 1'b1;
            if (j_reg == i_reg) begin
              xi_reg <= b_word;
            end
            if (j_inc < n_reg) begin
              RAM_Address_RD_A <= aptr_reg + 1'b1;
              RAM_Address_RD_B <= XINIT_ADDR + j_inc;
              state_reg        <= FETCH;
            end else if (upd_ovf) begin
              Error_Flag <= 1'b1;
              Euler_End  <= 1'b1;
              state_reg  <= DONE;
            end else begin
              Euler_Memory_WR_Enable <= 1'b1;
              RAM_Address_WR         <= XPROC_ADDR + i_reg;
              RAM_Data_WR            <= {{(DATA_WIDTH-16){xn_next[15]}}, xn_next};
              state_reg              <= UPDATE;
            end
          end
        end
        UPDATE: begin
          i_reg <= i_inc;
          if (i_inc < n_reg) begin
            state_reg <= ROW_INIT;
          end else begin
            Euler_End <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (!Euler_Enable) begin
            Euler_End <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
